// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-access target.
// Holds the FSM state encoding, ack polarity and default device ids.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } sccb_state_t;

  localparam logic SCCB_ACK  = 1'b0;
  localparam logic SCCB_NACK = 1'b1;

  localparam logic [7:0] SCCB_WR_ID = 8'h42;
  localparam logic [7:0] SCCB_RD_ID = 8'h43;

endpackage

// File: rtl/sccb_target_if.sv
// Bus lines and register-file port of the SCCB target.
// The slave modport is the target's view; master is the bus/regfile side.
interface sccb_target_if;

  logic       sioc;
  logic       siod_in;
  logic       siod_oe;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  sioc, siod_in, reg_rdata,
    output siod_oe, reg_wr, reg_rd, reg_addr, reg_wdata, busy
  );

  modport master (
    output sioc, siod_in, reg_rdata,
    input  siod_oe, reg_wr, reg_rd, reg_addr, reg_wdata, busy
  );

endinterface

// File: rtl/sccb_line_sync.sv
// Synchronizes sioc/siod into clk_50Mhz and derives single-cycle
// SCL edge, START and STOP pulses from the synchronized lines.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50Mhz,
  input  logic rst,
  input  logic sioc,
  input  logic siod_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_p0;
  logic [SYNC_STAGES-1:0] sda_sync_p0;
  logic                   scl_p1;
  logic                   sda_p1;
  logic                   scl;

  // Both chains reset to the idle-bus level and have equal length, so a
  // simultaneous change on the pins appears in the same cycle on both.
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_p1      <= 1'b1;
      sda_p1      <= 1'b1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], sioc};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], siod_in};
      scl_p1      <= scl_sync_p0[SYNC_STAGES-1];
      sda_p1      <= sda_sync_p0[SYNC_STAGES-1];
    end
  end

  assign scl = scl_sync_p0[SYNC_STAGES-1];
  assign sda = sda_sync_p0[SYNC_STAGES-1];

  assign scl_rise  = scl & ~scl_p1;
  assign scl_fall  = ~scl & scl_p1;
  // sioc must be high in both samples, which rejects same-sample changes.
  assign start_det = scl & scl_p1 & sda_p1 & ~sda;
  assign stop_det  = scl & scl_p1 & ~sda_p1 & sda;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C-compatible register-access target: decodes the device address,
// turns writes into reg_wr strobes and serves reads from a one-cycle port.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk_50Mhz,
  input  logic         rst,
  sccb_target_if.slave bus
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .sioc      (bus.sioc),
    .siod_in   (bus.siod_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  sccb_state_t state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  sh, sh_nx;
  logic        oe, oe_nx;
  logic [7:0]  addr, addr_nx;
  logic [7:0]  wdata, wdata_nx;
  logic        wr, wr_nx;
  logic        busy, busy_nx;
  logic        rw, rw_nx;
  logic        rd_c;
  logic        load_p1;
  logic [7:0]  byte_in;

  assign byte_in = {sh[6:0], sda};

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sh      <= '0;
      oe      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      wr      <= 1'b0;
      busy    <= 1'b0;
      rw      <= 1'b0;
      load_p1 <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sh      <= sh_nx;
      oe      <= oe_nx;
      addr    <= addr_nx;
      wdata   <= wdata_nx;
      wr      <= wr_nx;
      busy    <= busy_nx;
      rw      <= rw_nx;
      load_p1 <= rd_c;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    oe_nx    = oe;
    addr_nx  = addr;
    wdata_nx = wdata;
    wr_nx    = 1'b0;
    busy_nx  = busy;
    rw_nx    = rw;
    rd_c     = 1'b0;

    if (start_det) begin
      state_nx = ST_ADDR;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
    end else if (stop_det) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else begin
      // Receive states share the MSB-first shifter; cnt wraps 7 -> 0.
      if ((state == ST_ADDR || state == ST_REG || state == ST_WDATA) && scl_rise) begin
        sh_nx  = byte_in;
        cnt_nx = cnt + 3'd1;
      end

      unique case (state)
        ST_IDLE, ST_IGNORE: oe_nx = 1'b0;

        ST_ADDR:
          if (scl_rise && cnt == 3'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_nx = ST_ADDR_ACK;
              busy_nx  = 1'b1;
              rw_nx    = byte_in[0];
            end else begin
              state_nx = ST_IGNORE;
              busy_nx  = 1'b0;
            end
          end

        ST_REG:
          if (scl_rise && cnt == 3'd7) begin
            addr_nx  = byte_in;
            state_nx = ST_REG_ACK;
          end

        ST_WDATA:
          if (scl_rise && cnt == 3'd7) begin
            wr_nx    = 1'b1;
            wdata_nx = byte_in;
            state_nx = ST_WDATA_ACK;
          end

        // cnt = 0 waits for the fall ending bit 8, cnt = 1 for the one ending the ack.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK:
          if (scl_fall) begin
            if (cnt == 3'd0) begin
              oe_nx  = 1'b1;
              cnt_nx = 3'd1;
            end else begin
              oe_nx  = 1'b0;
              cnt_nx = '0;
              if (state == ST_ADDR_ACK) begin
                if (rw) begin
                  state_nx = ST_RDATA;
                  rd_c     = 1'b1;
                end else begin
                  state_nx = ST_REG;
                end
              end else if (state == ST_REG_ACK) begin
                state_nx = ST_WDATA;
              end else begin
                addr_nx  = addr + 8'd1;
                state_nx = ST_WDATA;
              end
            end
          end

        ST_RDATA:
          if (load_p1) begin
            sh_nx  = bus.reg_rdata;
            oe_nx  = ~bus.reg_rdata[7];
            cnt_nx = '0;
          end else if (scl_fall) begin
            if (cnt == 3'd7) begin
              oe_nx    = 1'b0;
              cnt_nx   = '0;
              state_nx = ST_RDATA_ACK;
            end else begin
              sh_nx  = {sh[6:0], 1'b0};
              oe_nx  = ~sh[6];
              cnt_nx = cnt + 3'd1;
            end
          end

        ST_RDATA_ACK:
          if (scl_rise && cnt == 3'd0) begin
            if (sda == SCCB_NACK) begin
              state_nx = ST_IGNORE;
            end else begin
              addr_nx = addr + 8'd1;
              cnt_nx  = 3'd1;
            end
          end else if (scl_fall && cnt == 3'd1) begin
            rd_c     = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_RDATA;
          end

        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign bus.siod_oe   = oe;
  assign bus.reg_wr    = wr;
  assign bus.reg_rd    = rd_c;
  assign bus.reg_addr  = addr;
  assign bus.reg_wdata = wdata;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB master, open-drain line
// model and a small register file answering reg_rd.
module tb_sccb_target;
  import sccb_pkg::*;

  localparam int Q = 10;

  logic clk_50Mhz;
  logic rst;
  logic m_sda;

  sccb_target_if bus ();

  sccb_target #(
    .DEV_ADDR    (7'h21),
    .SYNC_STAGES (2)
  ) dut (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .bus       (bus.slave)
  );

  assign bus.siod_in = m_sda & ~bus.siod_oe;

  initial clk_50Mhz = 1'b0;
  always #10 clk_50Mhz = ~clk_50Mhz;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both   = 0;
  logic [7:0] wr_a [0:31];
  logic [7:0] wr_d [0:31];
  logic [7:0] rd_a [0:31];

  always @(posedge clk_50Mhz) begin
    if (bus.reg_rd) bus.reg_rdata <= mem[bus.reg_addr];
    if (bus.reg_wr && bus.reg_rd) both <= both + 1;
    if (bus.reg_wr) begin
      wr_a[wr_cnt[4:0]] <= bus.reg_addr;
      wr_d[wr_cnt[4:0]] <= bus.reg_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.reg_rd) begin
      rd_a[rd_cnt[4:0]] <= bus.reg_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50Mhz);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; bus.sioc = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    bus.sioc = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; tick(Q);
    bus.sioc = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    bus.sioc = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    bus.sioc = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(Q);
    bus.sioc = 1'b1; tick(Q);
    bus.sioc = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; tick(Q);
    bus.sioc = 1'b1; tick(Q);
    ack = bus.siod_oe;
    bus.sioc = 1'b0; tick(Q);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; tick(Q);
      bus.sioc = 1'b1; tick(Q);
      d[i] = bus.siod_in;
      bus.sioc = 1'b0; tick(Q);
    end
    m_sda = master_ack ? 1'b0 : 1'b1; tick(Q);
    bus.sioc = 1'b1; tick(Q);
    bus.sioc = 1'b0; tick(Q);
  endtask

  logic a0, a1, a2, a3;
  logic [7:0] d;
  int w0, r0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h0A] = 8'hA5;
    mem[8'h0B] = 8'h3C;
    bus.reg_rdata = 8'h00;
    m_sda = 1'b1;
    bus.sioc = 1'b1;
    rst = 1'b1;
    tick(5);

    check("rst_oe",    32'(bus.siod_oe),   32'h0);
    check("rst_wr",    32'(bus.reg_wr),    32'h0);
    check("rst_rd",    32'(bus.reg_rd),    32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);
    check("rst_addr",  32'(bus.reg_addr),  32'h00);
    check("rst_wdata", 32'(bus.reg_wdata), 32'h00);
    check("rst_state", 32'(dut.state),     32'(ST_IDLE));
    rst = 1'b0;
    tick(5);

    // Single write 0x12 <= 0x80
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h12, a1); send_byte(8'h80, a2);
    check("wr_acks", 32'({a0, a1, a2}), 32'h7);
    check("wr_busy", 32'(bus.busy), 32'h1);
    bus_stop();
    check("wr_busy_stop", 32'(bus.busy), 32'h0);
    check("wr_idle", 32'(dut.state), 32'(ST_IDLE));
    check("wr_count", 32'(wr_cnt - w0), 32'd1);
    check("wr_addr", 32'(wr_a[w0[4:0]]), 32'h12);
    check("wr_data", 32'(wr_d[w0[4:0]]), 32'h80);

    // Foreign address: no ack, no write
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h60, a0); send_byte(8'h12, a1); send_byte(8'h80, a2);
    check("nm_acks", 32'({a0, a1, a2}), 32'h0);
    check("nm_busy", 32'(bus.busy), 32'h0);
    check("nm_state", 32'(dut.state), 32'(ST_IGNORE));
    check("nm_count", 32'(wr_cnt - w0), 32'd0);
    bus_stop();
    check("nm_idle", 32'(dut.state), 32'(ST_IDLE));

    // Burst with pointer wrap
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, a0); send_byte(8'hFF, a1); send_byte(8'h11, a2); send_byte(8'h22, a3);
    bus_stop();
    check("bu_acks", 32'({a0, a1, a2, a3}), 32'hF);
    check("bu_count", 32'(wr_cnt - w0), 32'd2);
    check("bu_addr0", 32'(wr_a[w0[4:0]]), 32'hFF);
    check("bu_data0", 32'(wr_d[w0[4:0]]), 32'h11);
    check("bu_addr1", 32'(wr_a[5'(w0 + 1)]), 32'h00);
    check("bu_data1", 32'(wr_d[5'(w0 + 1)]), 32'h22);

    // Read 0x0A, 0x0B with repeated START
    w0 = wr_cnt;
    r0 = rd_cnt;
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h0A, a1);
    bus_rstart();
    send_byte(8'h43, a2);
    check("rd_acks", 32'({a0, a1, a2}), 32'h7);
    read_byte(d, 1'b1);
    check("rd_byte0", 32'(d), 32'hA5);
    check("rd_addr0", 32'(rd_a[r0[4:0]]), 32'h0A);
    read_byte(d, 1'b0);
    check("rd_byte1", 32'(d), 32'h3C);
    check("rd_addr1", 32'(rd_a[5'(r0 + 1)]), 32'h0B);
    check("rd_count", 32'(rd_cnt - r0), 32'd2);
    check("rd_nack_state", 32'(dut.state), 32'(ST_IGNORE));
    bus_stop();
    check("rd_idle", 32'(dut.state), 32'(ST_IDLE));
    check("rd_no_wr", 32'(wr_cnt - w0), 32'd0);

    // STOP after 5 data bits, then a clean write
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h33, a1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus_stop();
    check("ps_count", 32'(wr_cnt - w0), 32'd0);
    check("ps_oe", 32'(bus.siod_oe), 32'h0);
    check("ps_idle", 32'(dut.state), 32'(ST_IDLE));
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h20, a1); send_byte(8'h5A, a2);
    bus_stop();
    check("ps_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("ps_wr_addr", 32'(wr_a[w0[4:0]]), 32'h20);
    check("ps_wr_data", 32'(wr_d[w0[4:0]]), 32'h5A);

    // Reset while the target drives an ack, then a clean write
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, a0);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    m_sda = 1'b1; tick(Q);
    check("rs_ack_on", 32'(bus.siod_oe), 32'h1);
    rst = 1'b1;
    tick(1);
    check("rs_oe", 32'(bus.siod_oe), 32'h0);
    check("rs_state", 32'(dut.state), 32'(ST_IDLE));
    check("rs_busy", 32'(bus.busy), 32'h0);
    check("rs_addr", 32'(bus.reg_addr), 32'h00);
    tick(1);
    rst = 1'b0;
    tick(Q);
    bus_stop();
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h30, a1); send_byte(8'hC3, a2);
    bus_stop();
    check("rs_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("rs_wr_addr", 32'(wr_a[w0[4:0]]), 32'h30);
    check("rs_wr_data", 32'(wr_d[w0[4:0]]), 32'hC3);

    // sioc and siod change together: no START/STOP
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h40, a1);
    m_sda = 1'b0; tick(Q);
    bus.sioc = 1'b1; m_sda = 1'b1; tick(Q);
    check("sim_rise_state", 32'(dut.state), 32'(ST_WDATA));
    check("sim_rise_busy", 32'(bus.busy), 32'h1);
    bus.sioc = 1'b0; m_sda = 1'b0; tick(Q);
    check("sim_fall_state", 32'(dut.state), 32'(ST_WDATA));
    check("sim_fall_busy", 32'(bus.busy), 32'h1);
    bus_stop();
    check("sim_idle", 32'(dut.state), 32'(ST_IDLE));
    check("sim_no_wr", 32'(wr_cnt - w0), 32'd0);

    check("wr_rd_overlap", 32'(both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
